// File: rtl/spi_flash_read_ctrl_if.sv
// Request/response bundle between user logic and the SPI flash read controller.
// The controller side uses the slave modport; user logic uses master.
interface spi_flash_read_ctrl_if #(
  parameter int LEN_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, rd_ready,
    input  cmd_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, rd_ready,
    output cmd_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/spi_flash_read_ctrl.sv
// SPI configuration-flash reader: optional release-from-power-down after reset,
// then READ (0x03) + 24-bit address in mode 0, bytes streamed out through a
// one-byte holding register with valid/ready backpressure.
//
// state     | meaning
// WAKE_TX   | shifting 0xAB (release from power-down)
// WAKE_WAIT | SS high, waiting T_WAKE clocks for the flash to wake
// IDLE      | cmd_ready high, waiting for a request
// CMD       | shifting the 0x03 opcode
// ADDR      | shifting the 24-bit address, MSB first
// DATA      | sampling read bytes; after the last one, SS high until drained
// GAP       | SS high for CS_HIGH clocks before the next request
module spi_flash_read_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter bit WAKE_ON_RESET = 1'b1,
  parameter int T_WAKE        = 288,
  parameter int CS_HIGH       = 8,
  parameter int LEN_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  spi_flash_read_ctrl_if.slave bus,
  output logic                spi_ss_o,
  output logic                spi_sck_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i
);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int WAKE_W = $clog2(T_WAKE + 1);
  localparam int GAP_W  = $clog2(CS_HIGH + 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'((T_WAKE > 0) ? T_WAKE - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((CS_HIGH > 0) ? CS_HIGH - 1 : 0);

  typedef enum logic [2:0] {
    WAKE_TX, WAKE_WAIT, IDLE, CMD, ADDR, DATA, GAP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [LEN_W-1:0]  byte_cnt;
  logic [31:0]       sh_out;
  logic [7:0]        sh_in;
  logic              pend;
  logic              lead;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              done_q;
  logic              ss_q;
  logic              sck_q;
  logic              mosi_q;

  // Sequencer, bit engine and holding register in one registered process.
  // lead marks the single SS-low cycle that precedes the first low phase;
  // pend marks a completed byte in sh_in still waiting for the holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAKE_ON_RESET ? WAKE_TX : IDLE;
      div_cnt    <= '0;
      bit_cnt    <= 5'd7;
      wake_cnt   <= '0;
      gap_cnt    <= '0;
      byte_cnt   <= '0;
      sh_out     <= {8'hAB, 24'h0};
      sh_in      <= '0;
      pend       <= 1'b0;
      lead       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Acceptance frees the holding register; a pending byte moves in on the following clock.
      if (rd_valid_q && bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end else if (pend && !rd_valid_q) begin
        rd_data_q  <= sh_in;
        rd_valid_q <= 1'b1;
        pend       <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state    <= CMD;
              ss_q     <= 1'b0;
              lead     <= 1'b1;
              sh_out   <= {8'h03, bus.cmd_addr};
              bit_cnt  <= 5'd31;
              byte_cnt <= bus.cmd_len;
            end
          end
        end
        WAKE_WAIT: begin
          if (wake_cnt == '0) state <= IDLE;
          else wake_cnt <= wake_cnt - 1'b1;
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          if (ss_q) begin
            // SS high here means either the first cycle after reset (wake) or
            // the drain wait after the last byte of a read.
            if (state == WAKE_TX) begin
              ss_q <= 1'b0;
              lead <= 1'b1;
            end else if (!pend && (!rd_valid_q || bus.rd_ready)) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (lead) begin
            lead    <= 1'b0;
            div_cnt <= DIV_LOAD;
            mosi_q  <= sh_out[31];
            sh_out  <= {sh_out[30:0], 1'b0};
          end else if (!sck_q) begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else if (!pend) begin
              // Rising edge; withheld while a completed byte cannot be stored.
              sck_q   <= 1'b1;
              div_cnt <= DIV_LOAD;
              if (state == DATA) begin
                sh_in <= {sh_in[6:0], spi_miso_i};
                if (bit_cnt == 5'd0) begin
                  pend     <= 1'b1;
                  byte_cnt <= byte_cnt - 1'b1;
                end
              end
            end
          end else begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else begin
              sck_q   <= 1'b0;
              div_cnt <= DIV_LOAD;
              bit_cnt <= bit_cnt - 5'd1;
              mosi_q  <= sh_out[31];
              sh_out  <= {sh_out[30:0], 1'b0};
              case (state)
                WAKE_TX: begin
                  if (bit_cnt == 5'd0) begin
                    state    <= WAKE_WAIT;
                    ss_q     <= 1'b1;
                    mosi_q   <= 1'b0;
                    wake_cnt <= WAKE_LOAD;
                  end
                end
                CMD: begin
                  if (bit_cnt == 5'd24) state <= ADDR;
                end
                ADDR: begin
                  if (bit_cnt == 5'd0) begin
                    state   <= DATA;
                    bit_cnt <= 5'd7;
                    mosi_q  <= 1'b0;
                  end
                end
                default: begin
                  mosi_q <= 1'b0;
                  if (bit_cnt == 5'd0) begin
                    if (byte_cnt == '0) ss_q <= 1'b1;
                    else bit_cnt <= 5'd7;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // done must coincide with acceptance of the final byte, so that term is
  // decoded from registered state and the consumer's rd_ready.
  assign bus.done      = done_q | ((state == DATA) && (byte_cnt == '0) && !pend &&
                                   rd_valid_q && bus.rd_ready);
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign spi_ss_o      = ss_q;
  assign spi_sck_o     = sck_q;
  assign spi_mosi_o    = mosi_q;
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Directed bench for spi_flash_read_ctrl with a behavioural mode-0 flash model.
module tb_spi_flash_read_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_ss_o, spi_sck_o, spi_mosi_o, spi_miso_i;

  spi_flash_read_ctrl_if #(.LEN_W(16)) bus ();

  spi_flash_read_ctrl #(
    .CLK_DIV(2), .WAKE_ON_RESET(1'b1), .T_WAKE(288), .CS_HIGH(8), .LEN_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_ss_o(spi_ss_o), .spi_sck_o(spi_sck_o),
    .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Flash model contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h050000: return 8'hDE;
      24'h050001: return 8'hAD;
      24'h050002: return 8'hBE;
      24'h000000: return 8'h5A;
      24'h000001: return 8'h3C;
      default:    return a[7:0] ^ 8'h96;
    endcase
  endfunction

  int          bitn = 0;
  int          sck_rises = 0;
  logic [31:0] rx = '0;
  logic [7:0]  cmd_l = '0;
  logic [23:0] addr_l = '0;
  logic        miso = 1'b0;
  int          mk;
  logic [7:0]  mcur;

  assign spi_miso_i = miso;

  // Flash: capture MOSI on rising SCK, restart framing when SS rises
  always @(posedge spi_sck_o or posedge spi_ss_o) begin
    if (spi_ss_o) begin
      bitn <= 0;
    end else begin
      rx <= {rx[30:0], spi_mosi_o};
      if (bitn == 31) begin
        cmd_l  <= rx[30:23];
        addr_l <= {rx[22:0], spi_mosi_o};
      end
      bitn      <= bitn + 1;
      sck_rises <= sck_rises + 1;
    end
  end

  // Flash: drive read data on falling SCK once command and address are in
  always @(negedge spi_sck_o) begin
    if (!spi_ss_o && bitn >= 32) begin
      mk   = bitn - 32;
      mcur = flash_byte(addr_l + 24'(mk / 8));
      miso <= mcur[7 - (mk % 8)];
    end
  end

  logic [7:0] rxq[$];
  int done_cnt = 0;
  int acc_cnt = 0;
  int ss_hi_run = 0;

  // Bus monitor
  always @(posedge clk) begin
    if (bus.rd_valid && bus.rd_ready && !rst) rxq.push_back(bus.rd_data);
    if (bus.done) done_cnt++;
    if (bus.cmd_valid && bus.cmd_ready && !rst) acc_cnt++;
    if (spi_ss_o) ss_hi_run++;
    else ss_hi_run = 0;
  end

  task automatic wait_ready(input string tag);
    bit got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) got = 1;
    end
    compared++;
    if (!got) begin mismatched++; $display("FAIL %s_ready_timeout: cmd_ready got 0 want 1", tag); end
  endtask

  task automatic wait_done(input string tag, input int d0);
    bit got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt > d0) got = 1;
    end
    compared++;
    if (!got) begin mismatched++; $display("FAIL %s_done_timeout: done count got %0d want %0d", tag, done_cnt - d0, 1); end
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] len);
    wait_ready("issue");
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int r0;
    bit busy_bad = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (spi_ss_o !== 1'b1) begin mismatched++; $display("FAIL reset_ss: got %b want 1", spi_ss_o); end
    compared++; if (spi_sck_o !== 1'b0) begin mismatched++; $display("FAIL reset_sck: got %b want 0", spi_sck_o); end
    compared++; if (spi_mosi_o !== 1'b0) begin mismatched++; $display("FAIL reset_mosi: got %b want 0", spi_mosi_o); end
    compared++; if (bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    compared++; if (bus.rd_data !== 8'h00) begin mismatched++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", bus.done); end
    compared++; if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    r0 = sck_rises;
    rst = 1'b0;
    for (int i = 0; i < 3000 && bus.cmd_ready !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b1 && bus.busy !== 1'b1) busy_bad = 1;
    end
    compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL wake_ready_timeout: cmd_ready got %b want 1", bus.cmd_ready); end
    compared++; if (busy_bad) begin mismatched++; $display("FAIL wake_busy: busy got 0 want 1 during wake"); end
    compared++; if (sck_rises - r0 != 8) begin mismatched++; $display("FAIL wake_edges: got %0d want 8", sck_rises - r0); end
    compared++; if (rx[7:0] !== 8'hAB) begin mismatched++; $display("FAIL wake_mosi: got %h want ab", rx[7:0]); end
    compared++; if (ss_hi_run < 288) begin mismatched++; $display("FAIL wake_ss_high: got %0d want >=288", ss_hi_run); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_read();
    int r0 = sck_rises, d0 = done_cnt, b = rxq.size();
    bus.rd_ready = 1'b1;
    issue(24'h050000, 16'd3);
    wait_done("read", d0);
    wait_ready("read");
    compared++; if (cmd_l !== 8'h03) begin mismatched++; $display("FAIL read_cmd: got %h want 03", cmd_l); end
    compared++; if (addr_l !== 24'h050000) begin mismatched++; $display("FAIL read_addr: got %h want 050000", addr_l); end
    compared++; if (sck_rises - r0 != 56) begin mismatched++; $display("FAIL read_edges: got %0d want 56", sck_rises - r0); end
    compared++; if (rxq.size() - b != 3) begin mismatched++; $display("FAIL read_count: got %0d want 3", rxq.size() - b); end
    compared++; if ({rxq[b], rxq[b+1], rxq[b+2]} !== 24'hDEADBE) begin mismatched++; $display("FAIL read_data: got %h%h%h want deadbe", rxq[b], rxq[b+1], rxq[b+2]); end
    compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL read_done: got %0d want 1", done_cnt - d0); end
    compared++; if (ss_hi_run < 8) begin mismatched++; $display("FAIL read_gap: got %0d want >=8", ss_hi_run); end
  endtask

  task automatic test_backpressure();
    int r0 = sck_rises, d0 = done_cnt, b = rxq.size();
    bit got = 0, stable_bad = 0;
    bus.rd_ready = 1'b0;
    issue(24'h050000, 16'd3);
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) got = 1;
    end
    compared++; if (!got) begin mismatched++; $display("FAIL bp_valid_timeout: rd_valid got 0 want 1"); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hDE) stable_bad = 1;
    end
    compared++; if (stable_bad) begin mismatched++; $display("FAIL bp_hold: rd_data %h valid %b want de 1", bus.rd_data, bus.rd_valid); end
    compared++; if (sck_rises - r0 != 48) begin mismatched++; $display("FAIL bp_stall_edges: got %0d want 48", sck_rises - r0); end
    compared++; if (spi_sck_o !== 1'b0 || spi_ss_o !== 1'b0) begin mismatched++; $display("FAIL bp_stall_pins: sck %b ss %b want 0 0", spi_sck_o, spi_ss_o); end
    bus.rd_ready = 1'b1;
    wait_done("bp", d0);
    wait_ready("bp");
    compared++; if (sck_rises - r0 != 56) begin mismatched++; $display("FAIL bp_edges: got %0d want 56", sck_rises - r0); end
    compared++; if (rxq.size() - b != 3) begin mismatched++; $display("FAIL bp_count: got %0d want 3", rxq.size() - b); end
    compared++; if ({rxq[b], rxq[b+1], rxq[b+2]} !== 24'hDEADBE) begin mismatched++; $display("FAIL bp_data: got %h%h%h want deadbe", rxq[b], rxq[b+1], rxq[b+2]); end
    compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_len_zero();
    int d0, r0;
    wait_ready("len0");
    d0 = done_cnt;
    r0 = sck_rises;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 24'h123456;
    bus.cmd_len   = 16'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    compared++; if (bus.done !== 1'b1) begin mismatched++; $display("FAIL len0_done: got %b want 1", bus.done); end
    compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL len0_ready: got %b want 1", bus.cmd_ready); end
    compared++; if (spi_ss_o !== 1'b1) begin mismatched++; $display("FAIL len0_ss: got %b want 1", spi_ss_o); end
    @(negedge clk);
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("FAIL len0_pulse: got %b want 0", bus.done); end
    compared++; if (done_cnt - d0 != 1 || sck_rises != r0) begin mismatched++; $display("FAIL len0_count: done %0d edges %0d want 1 0", done_cnt - d0, sck_rises - r0); end
  endtask

  task automatic test_ignore();
    int a0, d0, b;
    wait_ready("ign");
    a0 = acc_cnt; d0 = done_cnt; b = rxq.size();
    bus.rd_ready  = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 24'h050000;
    bus.cmd_len   = 16'd2;
    @(negedge clk);
    bus.cmd_addr  = 24'h000000;
    bus.cmd_len   = 16'd1;
    wait_ready("ign");
    compared++; if (acc_cnt - a0 != 1) begin mismatched++; $display("FAIL ign_accepts: got %0d want 1", acc_cnt - a0); end
    compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL ign_done: got %0d want 1", done_cnt - d0); end
    compared++; if (rxq.size() - b != 2 || {rxq[b], rxq[b+1]} !== 16'hDEAD) begin mismatched++; $display("FAIL ign_data: got %0d bytes %h%h want 2 dead", rxq.size() - b, rxq[b], rxq[b+1]); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done("ign2", d0 + 1);
    compared++; if (acc_cnt - a0 != 2) begin mismatched++; $display("FAIL ign_second_accept: got %0d want 2", acc_cnt - a0); end
    compared++; if (rxq.size() - b != 3 || rxq[b+2] !== 8'h5A) begin mismatched++; $display("FAIL ign_second_data: got %h want 5a", rxq[b+2]); end
  endtask

  task automatic test_reset_mid();
    int d0, b, r0;
    bit got = 0;
    bus.rd_ready = 1'b1;
    d0 = done_cnt; b = rxq.size();
    issue(24'h050000, 16'd3);
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bitn >= 18) got = 1;
    end
    compared++; if (!got) begin mismatched++; $display("FAIL mid_addr_timeout: bits got %0d want 18", bitn); end
    rst = 1'b1;
    @(negedge clk);
    compared++; if (spi_ss_o !== 1'b1 || spi_sck_o !== 1'b0 || bus.rd_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_pins: ss %b sck %b valid %b want 1 0 0", spi_ss_o, spi_sck_o, bus.rd_valid); end
    r0 = sck_rises;
    rst = 1'b0;
    wait_ready("mid");
    compared++; if (done_cnt != d0) begin mismatched++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    compared++; if (sck_rises - r0 != 8 || rx[7:0] !== 8'hAB) begin mismatched++; $display("FAIL mid_rewake: edges %0d mosi %h want 8 ab", sck_rises - r0, rx[7:0]); end
    issue(24'h000000, 16'd1);
    wait_done("mid", d0);
    compared++; if (rxq.size() - b != 1 || rxq[b] !== 8'h5A) begin mismatched++; $display("FAIL mid_read: got %0d bytes %h want 1 5a", rxq.size() - b, rxq[b]); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b0;
    test_reset();
    test_read();
    test_backpressure();
    test_len_zero();
    test_ignore();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
- Sequences the on-board SPI configuration flash (spi_ss/spi_sck/spi_io0/spi_io1) so user logic can read bulk data, such as LED patterns or tables, stored after the bitstream.
- Issues optional release-from-power-down (0xAB) after reset, then serves read requests with standard READ (0x03) + 24-bit address in SPI mode 0.
- Streams bytes out on a valid/ready interface.
- The top level instantiates it on the clk_96 domain and drives the inout flash pins from its outputs; spi_io2/io3 stay 1'bz.

Parameters:
CLK_DIV, 4, system clocks per SCK half-period (>=1); SCK = f_clk/(2*CLK_DIV)
WAKE_ON_RESET, 1, 1 = send 0xAB then wait T_WAKE after every reset; 0 = go straight to IDLE
T_WAKE, 288, clocks SS held high after 0xAB before first read (3 us at 96 MHz)
CS_HIGH, 8, minimum clocks SS high between transactions
LEN_W, 16, width of byte-count field

Ports:
clk  in  1  system clock (clk_96 at top)
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  read request valid
cmd_ready  out  1  high only in IDLE; request accepted when cmd_valid&&cmd_ready
cmd_addr  in  24  flash byte address
cmd_len  in  LEN_W  bytes to read; 0 = no-op
rd_data  out  8  read byte, MSB first off the wire
rd_valid  out  1  rd_data valid; held with data stable until rd_ready
rd_ready  in  1  consumer accepts byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a request completes (incl. len 0)
spi_ss_o  out  1  chip select, active low
spi_sck_o  out  1  serial clock, idle low
spi_mosi_o  out  1  to spi_io0
spi_miso_i  in  1  from spi_io1

Behaviour:
- Reset values: spi_ss_o=1, spi_sck_o=0, spi_mosi_o=0, rd_valid=0, rd_data=0, done=0, cmd_ready=0. busy=1 if WAKE_ON_RESET, else busy=0 and cmd_ready=1 from the first cycle after reset.
- States: WAKE_TX -> WAKE_WAIT -> IDLE -> CMD -> ADDR -> DATA -> GAP -> IDLE.
- rst in any state returns immediately to the reset condition: SS high and SCK low next cycle, pending byte dropped, no done pulse.
- Bit timing, all shifting states: each bit lasts 2*CLK_DIV clocks.
  - Low phase: CLK_DIV clocks; MOSI updates on its first clock.
  - High phase: CLK_DIV clocks.
  - MISO is registered on the clock where SCK goes 0->1.
- SS falls one clock before the first low phase. SS rises one clock after the last high phase ends, with SCK already low.
- WAKE_TX: 8 bits of 0xAB, then SS high.
- WAKE_WAIT: count T_WAKE clocks, then IDLE.
- IDLE: on accept, latch addr and len.
  - len=0: done pulses the next cycle, SS stays high, return to IDLE.
  - Otherwise go to CMD.
- CMD: 8 bits of 0x03. ADDR: 24 bits, MSB first. MOSI is held 0 during DATA.
- DATA: shift 8 bits per byte. On the clock after the 8th sample, load rd_data and set rd_valid.
- Backpressure (one-byte holding register):
  - Shifting of the next byte continues while rd_valid is pending.
  - If a byte completes while rd_valid=1 and rd_ready=0, SCK is held low (no new rising edge) until the held byte is accepted. The completed byte is then loaded the cycle after acceptance.
  - No byte is ever lost or duplicated.
- Last byte: after the final sample, SS rises. The state waits in DATA until the final byte is accepted, then goes to GAP; done pulses on the cycle of final acceptance.
- GAP: SS high for CS_HIGH clocks, then IDLE (cmd_ready=1).
- cmd_valid outside IDLE is ignored; inputs are sampled only at accept.
- Address wrap past 0xFFFFFF is left to the flash, which wraps to 0; the controller does no address arithmetic.
- Counters: byte counter is LEN_W bits (down-count), bit counter 5 bits, divider ceil(log2(CLK_DIV+1)) bits, wake counter ceil(log2(T_WAKE+1)) bits.

Test Plan:
1. Reset, WAKE_ON_RESET=1, CLK_DIV=2 -> SS low, exactly 8 SCK rising edges with MOSI bits 1,0,1,0,1,0,1,1 (0xAB), SS high >= 288 clocks, then cmd_ready=1; busy=1 throughout until then.
2. Flash model holds 0xDE,0xAD,0xBE at 0x050000; request addr=0x050000, len=3, rd_ready=1 -> MOSI shows 0x03,0x05,0x00,0x00; 56 SCK rising edges total; rd_data sequence DE,AD,BE; one done pulse; SS high >= 8 clocks before cmd_ready.
3. Same read, rd_ready=0 until 200 clocks after first rd_valid -> SCK stops low after byte 2 completes, rd_data stays 0xDE stable; after release, bytes AD,BE delivered with no loss; total SCK edges still 56.
4. len=0, addr=0x123456 -> done pulses the cycle after accept, SS never low, cmd_ready back next cycle.
5. rst asserted mid-ADDR (after 10 address bits) -> next cycle SS=1, SCK=0, rd_valid=0, no done pulse; wake sequence repeats; a following len=1 read of 0x000000 returns the model byte correctly.
6. cmd_valid held high during an active len=2 read with a different addr -> ignored; only one transaction and one done pulse occur, and the second request is accepted only when cmd_ready rises.
